// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory write buffer (mem_write_buffer, wb_fifo).
// Buffer entries are sized by WB_XLEN; the top-level XLEN parameter must match it.
package mem_wb_pkg;

  localparam int WB_XLEN          = 32;
  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_ISSUE = 2'd1,
    S_RD_ISSUE = 2'd2,
    S_RD_DONE  = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [WB_XLEN-1:2] addr;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-buffer storage: circular FIFO with wrap-bit pointers, exposing every entry and a valid
// mask for the forwarding comparator. Under WB_COALESCE_EN an extra in-place data write port exists.
module wb_fifo
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WB_XLEN-1:2]         push_addr_i,
  input  logic [WB_XLEN-1:0]         push_data_i,
  input  logic                       pop_i,
`ifdef WB_COALESCE_EN
  input  logic                       coal_i,
  input  logic [$clog2(DEPTH)-1:0]   coal_idx_i,
  input  logic [WB_XLEN-1:0]         coal_data_i,
`endif
  output logic [WB_XLEN-1:2]         addr_o [DEPTH],
  output logic [WB_XLEN-1:0]         data_o [DEPTH],
  output logic [DEPTH-1:0]           valid_o,
  output logic [$clog2(DEPTH)-1:0]   head_idx_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] count;
  logic [AW-1:0] off;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head_idx_o = rd_ptr_q[AW-1:0];

  // An entry is live when its distance from the head is below the occupancy count.
  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = AW'(i) - rd_ptr_q[AW-1:0];
      valid_o[i] = ({1'b0, off} < count);
      addr_o[i]  = mem_q[i].addr;
      data_o[i]  = mem_q[i].data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Payload storage needs no reset: validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: push_addr_i, data: push_data_i};
`ifdef WB_COALESCE_EN
    if (coal_i) mem_q[coal_idx_i].data <= coal_data_i;
`endif
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Write buffer between the data cache and RAM: queues writebacks, forwards queued data to read
// misses and arbitrates RAM reads/writes. Define WB_COALESCE_EN to merge same-address writes.
module mem_write_buffer
  import mem_wb_pkg::*;
#(
  parameter int XLEN  = WB_XLEN,
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cache_wr_en,
  input  logic [XLEN-1:0] cache_addr,
  input  logic [XLEN-1:0] cache_wd,
  input  logic            cache_rd_en,
  output logic [XLEN-1:0] cache_rd,
  output logic            mem_stall,
  output logic            ram_req,
  output logic            ram_we,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  input  logic            ram_ready,
  input  logic [XLEN-1:0] ram_rdata,
  output logic            wb_empty,
  output logic [1:0]      dbg_state
);

  localparam int AW = $clog2(DEPTH);

  wb_state_t       state_q;
  logic            ram_req_q, ram_we_q;
  logic [XLEN-1:0] ram_addr_q, ram_wdata_q, rd_q;

  logic [XLEN-1:2] f_addr [DEPTH];
  logic [XLEN-1:0] f_data [DEPTH];
  logic [DEPTH-1:0] f_valid;
  logic [AW-1:0]   head_idx, idx;
  logic            full, empty, fwd_hit, push, pop, wr_coal;
  logic [XLEN-1:0] fwd_data, head_data;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^cache_addr[1:0];

  // Walk entries oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + AW'(k);
      if (f_valid[idx] && (f_addr[idx] == cache_addr[XLEN-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = f_data[idx];
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic          coal_hit;
  logic [AW-1:0] coal_idx, cidx;

  // The head is excluded only while it is on the RAM bus; its data is already committed there.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    cidx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cidx = head_idx + AW'(k);
      if (f_valid[cidx] && (f_addr[cidx] == cache_addr[XLEN-1:2]) &&
          !((k == 0) && (state_q == S_WR_ISSUE))) begin
        coal_hit = 1'b1;
        coal_idx = cidx;
      end
    end
  end

  assign wr_coal   = cache_wr_en && coal_hit;
  // A merge into the head on the same edge it is launched must launch the merged data.
  assign head_data = (wr_coal && (coal_idx == head_idx)) ? cache_wd : f_data[head_idx];
`else
  assign wr_coal   = 1'b0;
  assign head_data = f_data[head_idx];
`endif

  assign push = cache_wr_en && !wr_coal;
  assign pop  = (state_q == S_WR_ISSUE) && ram_ready;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (cache_addr[XLEN-1:2]),
    .push_data_i (cache_wd),
    .pop_i       (pop),
`ifdef WB_COALESCE_EN
    .coal_i      (wr_coal),
    .coal_idx_i  (coal_idx),
    .coal_data_i (cache_wd),
`endif
    .addr_o      (f_addr),
    .data_o      (f_data),
    .valid_o     (f_valid),
    .head_idx_o  (head_idx),
    .full_o      (full),
    .empty_o     (empty)
  );

  // RAM handshake: ram_req with ram_we/ram_addr/ram_wdata is held unchanged from assertion
  // through the cycle ram_ready is high; the transaction completes on that rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cache_rd_en && !fwd_hit) begin
            state_q    <= S_RD_ISSUE;
            ram_req_q  <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= {cache_addr[XLEN-1:2], 2'b00};
          end else if (!empty) begin
            state_q     <= S_WR_ISSUE;
            ram_req_q   <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= {f_addr[head_idx], 2'b00};
            ram_wdata_q <= head_data;
          end
        end
        S_WR_ISSUE, S_RD_ISSUE: begin
          if (ram_ready) begin
            if (state_q == S_RD_ISSUE) rd_q <= ram_rdata;
            state_q     <= (state_q == S_RD_ISSUE) ? S_RD_DONE : S_IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
          end
        end
        S_RD_DONE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_stall = (cache_wr_en && full && !wr_coal) ||
                     (cache_rd_en && !fwd_hit && (state_q != S_RD_DONE));
  assign cache_rd  = (state_q == S_RD_DONE)     ? rd_q     :
                     (cache_rd_en && fwd_hit)   ? fwd_data : '0;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign wb_empty  = empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: directed scenarios then random traffic, all checked
// against a transaction-level model (queue of pending writes, pending-read bookkeeping).
module tb_mem_write_buffer;
  import mem_wb_pkg::*;

  localparam int DEPTH = 4;
`ifdef WB_COALESCE_EN
  localparam int EXP_COAL_WR = 1;
`else
  localparam int EXP_COAL_WR = 2;
`endif

  logic        clk, rst, cache_wr_en, cache_rd_en, ram_ready;
  logic [31:0] cache_addr, cache_wd, ram_rdata;
  logic [31:0] cache_rd, ram_addr, ram_wdata;
  logic        mem_stall, ram_req, ram_we, wb_empty;
  logic [1:0]  dbg_state;

  mem_write_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cache_wr_en(cache_wr_en), .cache_addr(cache_addr),
    .cache_wd(cache_wd), .cache_rd_en(cache_rd_en), .cache_rd(cache_rd),
    .mem_stall(mem_stall), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
    .wb_empty(wb_empty), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_tests = 0, n_fail = 0;
  logic [63:0] exp_q[$];              // {word-aligned addr, data}, oldest first
  logic        rd_pend, rd_done_now, rd_done_next;
  logic [31:0] rd_addr_exp, rd_exp;
  logic        served, wr_acc, last_stall;
  logic [31:0] last_rd, first_wr_addr;
  int          n_wr_hs, rdy_pct;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ram();
    ram_ready = ($urandom_range(1, 100) <= rdy_pct);
    ram_rdata = $urandom;
  endtask

  // One clock cycle: called at a falling edge with inputs already driven; checks every output
  // against the model, updates the model, and returns at the next falling edge.
  task automatic tick();
    logic        hit, coal, full_m, exp_stall;
    logic [31:0] fwd_d, exp_rd;
    int          ci;
    #1;
    hit = 1'b0; fwd_d = '0; coal = 1'b0; ci = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][63:34] == cache_addr[31:2]) begin hit = 1'b1; fwd_d = exp_q[i][31:0]; end
`ifdef WB_COALESCE_EN
    if (cache_wr_en)
      for (int i = 0; i < exp_q.size(); i++)
        if ((exp_q[i][63:34] == cache_addr[31:2]) && !(i == 0 && ram_req && ram_we)) begin
          coal = 1'b1; ci = i;
        end
`endif
    full_m    = (exp_q.size() == DEPTH);
    exp_stall = (cache_wr_en && full_m && !coal) || (cache_rd_en && !hit && !rd_done_now);
    exp_rd    = rd_done_now ? rd_exp : ((cache_rd_en && hit) ? fwd_d : 32'd0);
    chk("mem_stall", mem_stall, exp_stall);
    chk("cache_rd", cache_rd, exp_rd);
    chk("wb_empty", wb_empty, exp_q.size() == 0);
    if (!ram_req) chk("ram_idle_outputs", ram_addr | ram_wdata | {31'd0, ram_we}, 0);
    last_stall = mem_stall;
    last_rd    = cache_rd;
    served     = cache_rd_en && (rd_done_now || hit);
    wr_acc     = cache_wr_en && !(full_m && !coal);
    if (cache_rd_en && !hit && !rd_done_now && !rd_pend) begin
      rd_pend     = 1'b1;
      rd_addr_exp = {cache_addr[31:2], 2'b00};
    end
    if (ram_req && ram_ready) begin
      if (ram_we) begin
        if (n_wr_hs == 0) first_wr_addr = ram_addr;
        n_wr_hs++;
        if (exp_q.size() == 0) chk("ram_write_unexpected", 64'(exp_q.size()), 64'd1);
        else chk("ram_write", {ram_addr, ram_wdata}, exp_q[0]);
      end else begin
        chk("ram_read_pending", rd_pend, 1'b1);
        chk("ram_read_addr", ram_addr, rd_addr_exp);
        rd_exp       = ram_rdata;
        rd_done_next = 1'b1;
        rd_pend      = 1'b0;
      end
    end
    if (wr_acc) begin
      if (coal) exp_q[ci][31:0] = cache_wd;
      else      exp_q.push_back({cache_addr[31:2], 2'b00, cache_wd});
    end
    if (ram_req && ram_ready && ram_we && exp_q.size() != 0) void'(exp_q.pop_front());
    @(posedge clk);
    rd_done_now  = rd_done_next;
    rd_done_next = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    ram_ready = 1'b1; cache_wr_en = 1'b0; cache_rd_en = 1'b0;
    for (int t = 0; t < 40 && (exp_q.size() != 0 || ram_req); t++) tick();
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cache_wr_en = 0; cache_rd_en = 0; cache_addr = 0; cache_wd = 0;
    ram_ready = 0; ram_rdata = 0; rdy_pct = 100;
    rd_pend = 0; rd_done_now = 0; rd_done_next = 0; rd_addr_exp = 0; rd_exp = 0;
    served = 0; wr_acc = 0; last_stall = 0; last_rd = 0; first_wr_addr = 0; n_wr_hs = 0;

    // Reset values
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_cache_rd", cache_rd, 0);
    chk("rst_wb_empty", wb_empty, 1);
    chk("rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // Fill / full stall: RAM blocked, five writes, only four fit
    ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cache_wr_en = 1'b1;
      cache_addr  = 32'h100 + 32'(4 * i);
      cache_wd    = 32'hD000 + 32'(i);
      if (i == 4) begin #1; chk("full_stall", mem_stall, 1); end
      tick();
    end
    cache_wr_en = 1'b0;
    n_wr_hs = 0;
    drain();
    chk("full_first_ram_write", first_wr_addr, 32'h100);
    chk("full_drain_count", n_wr_hs, 4);

    // Forwarding: youngest of two same-address writes, no RAM read
    ram_ready = 1'b0;
    cache_wr_en = 1'b1; cache_addr = 32'h200; cache_wd = 32'hAAAA; tick();
    cache_wd = 32'hBBBB; tick();
    cache_wr_en = 1'b0; cache_rd_en = 1'b1; cache_addr = 32'h202;
    #1;
    chk("fwd_data", cache_rd, 32'hBBBB);
    chk("fwd_no_stall", mem_stall, 0);
    tick();
    cache_rd_en = 1'b0;
    #1;
    chk("fwd_no_ram_read", ram_req && !ram_we, 0);
    drain();

    // Read miss latency: empty FIFO, RAM answers immediately
    ram_ready = 1'b1; ram_rdata = 32'h1234;
    cache_rd_en = 1'b1; cache_addr = 32'h300;
    begin
      int stalls = 0;
      served = 1'b0;
      for (int t = 0; t < 20 && !served; t++) begin
        tick();
        if (last_stall) stalls++;
      end
      chk("rdmiss_served", served, 1);
      chk("rdmiss_stall_cycles", stalls, 2);
      chk("rdmiss_data", last_rd, 32'h1234);
    end
    cache_rd_en = 1'b0;
    tick();

    // Read priority: writes enqueued during a read, then a new miss beats the drain
    ram_ready = 1'b0; ram_rdata = 32'h5A5A;
    cache_rd_en = 1'b1; cache_addr = 32'h600; tick();
    cache_rd_en = 1'b0;
    cache_wr_en = 1'b1; cache_addr = 32'h500; cache_wd = 32'h11; tick();
    cache_addr = 32'h504; cache_wd = 32'h22; tick();
    cache_wr_en = 1'b0;
    cache_rd_en = 1'b1; cache_addr = 32'h600; ram_ready = 1'b1; tick();
    tick();
    chk("prio_first_read_served", served, 1);
    cache_addr = 32'h604; ram_ready = 1'b0;
    chk("prio_idle_with_entries", dbg_state, S_IDLE);
    tick();
    chk("prio_read_first_state", dbg_state, S_RD_ISSUE);
    chk("prio_read_first_bus", {ram_req, ram_we}, 2'b10);
    ram_ready = 1'b1; ram_rdata = 32'h6B6B; tick();
    tick();
    chk("prio_second_read_served", served, 1);
    cache_rd_en = 1'b0; ram_ready = 1'b0; tick();
    chk("pushpop_in_wr_issue", dbg_state, S_WR_ISSUE);
    n_wr_hs = 0;
    ram_ready = 1'b1; cache_wr_en = 1'b1; cache_addr = 32'h508; cache_wd = 32'h33; tick();
    cache_wr_en = 1'b0;
    drain();
    chk("pushpop_total_writes", n_wr_hs, 3);

    // Same-address writes: merged or drained separately depending on the build
    ram_ready = 1'b0; n_wr_hs = 0;
    cache_wr_en = 1'b1; cache_addr = 32'h400; cache_wd = 32'h1111; tick();
    cache_wd = 32'h2222; tick();
    cache_wr_en = 1'b0;
    drain();
    chk("coalesce_write_count", n_wr_hs, EXP_COAL_WR);

    // Asynchronous reset in the middle of a RAM write
    ram_ready = 1'b0;
    cache_wr_en = 1'b1; cache_addr = 32'h700; cache_wd = 32'h77; tick();
    cache_wr_en = 1'b0; tick();
    chk("mid_wr_req_before_reset", ram_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ram_req", ram_req, 0);
    chk("async_rst_ram_we", ram_we, 0);
    chk("async_rst_wb_empty", wb_empty, 1);
    exp_q.delete();
    rd_pend = 0; rd_done_now = 0; rd_done_next = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic        done;
      logic [31:0] a;
      op      = $urandom_range(0, 9);
      rdy_pct = $urandom_range(20, 100);
      a       = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      done    = 1'b0;
      if (op < 5) begin
        cache_wr_en = 1'b1; cache_addr = a; cache_wd = $urandom;
        for (int t = 0; t < 200 && !done; t++) begin drive_ram(); tick(); done = wr_acc; end
        if (!done) chk("rand_write_timeout", wr_acc, 1);
        cache_wr_en = 1'b0;
      end else if (op < 8) begin
        cache_rd_en = 1'b1; cache_addr = a;
        for (int t = 0; t < 200 && !done; t++) begin drive_ram(); tick(); done = served; end
        if (!done) chk("rand_read_timeout", served, 1);
        cache_rd_en = 1'b0;
      end else begin
        drive_ram(); tick();
      end
    end
    drain();
    chk("final_wb_empty", wb_empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Sits between the data cache's memory-side port and main RAM.
- Queues dirty-line writebacks in a small FIFO and drains them to a handshaked, variable-latency RAM.
- Forwards buffered data to cache read misses whose address matches a queued write.
- Issues RAM reads for all other misses.
- Produces `mem_stall` for the hazard unit.

## Interface
- `XLEN`, 32, address/data width
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `clk  in  1  clock; all state updates on rising edge`
- `rst  in  1  asynchronous, active-low reset (asserted at 0)`
- `cache_wr_en  in  1  writeback request from data cache`
- `cache_addr  in  XLEN  word address for read or write; bits [1:0] ignored`
- `cache_wd  in  XLEN  writeback data`
- `cache_rd_en  in  1  read-miss request (cache needs `cache_rd`)`
- `cache_rd  out  XLEN  read data to cache`
- `mem_stall  out  1  pipeline stall request`
- `ram_req  out  1  RAM transaction valid`
- `ram_we  out  1  1 = write, 0 = read`
- `ram_addr  out  XLEN  RAM address, word aligned`
- `ram_wdata  out  XLEN  RAM write data`
- `ram_ready  in  1  RAM completes the current transaction this cycle; `ram_rdata` is valid when reading`
- `ram_rdata  in  XLEN  RAM read data`
- `wb_empty  out  1  FIFO empty (for fence/debug)`

## Operation
- **FIFO**
  - Entry holds {addr[XLEN-1:2], data}.
  - Read and write pointers are `$clog2(DEPTH)+1` bits wide, so full/empty can be distinguished.
  - Pointers wrap modulo 2·DEPTH.
  - Full when the indices are equal and the wrap bits differ.
- **Enqueue**
  - Occurs on an edge when `cache_wr_en` && !full.
  - When full, the write is not accepted, regardless of any pop in the same cycle.
- **Forwarding**
  - Applies when `cache_rd_en` is high.
  - All valid entries are compared combinationally on addr[XLEN-1:2].
  - The youngest match drives `cache_rd` in the same cycle, with no stall and no RAM access.
- **FSM states:** IDLE, WR_ISSUE, RD_ISSUE, RD_DONE.
  - **IDLE**
    - `cache_rd_en` && no forward hit → RD_ISSUE. Reads have priority over draining.
    - Otherwise, if !empty → WR_ISSUE.
  - **WR_ISSUE**
    - Outputs: `ram_req`=1, `ram_we`=1, addr/data from the head entry.
    - On `ram_ready`: pop the head, then → IDLE.
  - **RD_ISSUE**
    - Outputs: `ram_req`=1, `ram_we`=0, `ram_addr`={`cache_addr`[XLEN-1:2],2'b00}.
    - On `ram_ready`: latch `ram_rdata` into rd_q, then → RD_DONE.
  - **RD_DONE**
    - Outputs: `cache_rd`=rd_q, `mem_stall`=0.
    - → IDLE unconditionally.
- **`mem_stall`** is high when any of the following holds:
  - `cache_wr_en` && full;
  - `cache_rd_en` && no forward hit && state≠RD_DONE.
- **Simultaneous events**
  - Enqueue and pop in the same cycle: both take effect; the count is unchanged.
  - A read miss arriving during WR_ISSUE waits for the write to complete.
  - An enqueue during a read is allowed.
- **Outputs outside the active states:** `ram_addr`, `ram_wdata`, `ram_we` are 0 when `ram_req`=0.
- **Reset values:** `mem_stall`=0, `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `cache_rd`=0, `wb_empty`=1, state=IDLE, pointers=0.
- **Reset mid-transaction:** the in-flight RAM transaction is abandoned and queued writes are lost.

## Timing
- Forwarded read: 0 stall cycles.
- RAM read with `ram_ready` on the first RD_ISSUE cycle: 2 stall cycles (IDLE cycle + RD_ISSUE cycle). Data is presented in RD_DONE.
- Each additional RAM wait cycle adds 1 stall cycle.
- Write drain: at least 1 cycle in WR_ISSUE per entry plus 1 IDLE cycle, i.e. at most one write every 2 cycles.
- `ram_req` and all RAM-side outputs are stable from assertion until the `ram_ready` cycle inclusive.

## Configuration
- **`WB_COALESCE_EN` defined**
  - An enqueue whose address matches a valid entry other than the head being issued in WR_ISSUE overwrites that entry's data in place.
  - The pointer does not advance.
  - Coalescing is accepted even when full.
- **`WB_COALESCE_EN` undefined**
  - Every accepted write allocates a new entry.
  - Duplicates drain in order.

## Structure
- **Package `mem_wb_pkg`**
  - `wb_state_t` enum.
  - `wb_entry_t` struct {addr, data}.
  - `WB_DEPTH_DEFAULT` constant.
- **Sub-module `wb_fifo`**
  - Storage and pointers, full/empty.
  - Exposes all entries plus a valid mask for the forwarding comparator.
  - The coalesce write port is present only under `WB_COALESCE_EN`.

## Test plan
- **Reset:**
  - Drive `rst`=0 asynchronously mid-WR_ISSUE → `ram_req` drops without a clock edge.
  - `wb_empty`=1.
- **Fill / full stall:**
  - Hold `ram_ready`=0 and enqueue 5 writes (addr 0x100..0x110) → first 4 accepted.
  - On the 5th, `mem_stall`=1.
  - Raise `ram_ready` → RAM sees 0x100 first, in order.
- **Forwarding:**
  - Enqueue 0x200←0xAAAA then 0x200←0xBBBB, then `cache_rd_en` to 0x200 → `cache_rd`=0xBBBB.
  - `mem_stall`=0 and no RAM read is issued.
- **Read miss latency:**
  - With FIFO empty, read 0x300 with RAM returning 0x1234 and `ram_ready` immediate → `mem_stall` high for exactly 2 cycles.
  - RD_DONE cycle shows 0x1234.
- **Read priority and simultaneous events:**
  - With 2 entries queued and state IDLE, a read miss → RD_ISSUE precedes the drain.
  - An enqueue during WR_ISSUE completion keeps the count at 2.
- **Coalesce:**
  - With `WB_COALESCE_EN`, enqueue 0x400 twice → a single RAM write carrying the second value.
  - Without the macro → two writes.
